// File: rtl/temp_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : temp_scan_pkg
//  Purpose  : Shared definitions for the temperature-sense pad scan controller:
//             scan state encoding, default sizing constants and a one-hot
//             decode helper for the switch-enable vectors.
//  Revision : 1.0  initial release
// ============================================================================
package temp_scan_pkg;

    // Default sizing for the production instance (18 primary + 18 secondary)
    localparam int NUM_SENSOR_DEF = 36;
    localparam int IDX_W_DEF      = 6;
    localparam int BBM_CYCLES_DEF = 2;
    localparam int SETTLE_W_DEF   = 8;
    localparam int DWELL_W_DEF    = 16;

    // Upper bound of the one-hot helper; instances must keep
    // NUM_SENSOR <= SEL_MAX and IDX_W <= IDX_MAX_W.
    localparam int IDX_MAX_W = 6;
    localparam int SEL_MAX   = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BREAK  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_NEXT   = 3'd4
    } scan_state_e;

    // One-hot decode of a sensor index; callers truncate to their width.
    function automatic logic [SEL_MAX-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
        logic [SEL_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mask_next_sel.sv
`default_nettype none
// ============================================================================
//  Module   : mask_next_sel
//  Purpose  : Combinational sensor-mask search. Returns the lowest set mask
//             bit strictly above the current index (plus found flag) and the
//             lowest set mask bit overall (plus non-zero flag).
//  Ports    : mask_i       - sensor inclusion mask
//             cur_idx_i    - index currently being driven
//             next_idx_o   - next-higher set index (valid when next_found_o)
//             next_found_o - a set bit exists above cur_idx_i
//             low_idx_o    - lowest set index (valid when nonzero_o)
//             nonzero_o    - mask has at least one bit set
//  Revision : 1.0  initial release
// ============================================================================
module mask_next_sel
    import temp_scan_pkg::*;
#(
    parameter int NUM_SENSOR = NUM_SENSOR_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic [NUM_SENSOR-1:0] mask_i,
    input  logic [IDX_W-1:0]      cur_idx_i,
    output logic [IDX_W-1:0]      next_idx_o,
    output logic                  next_found_o,
    output logic [IDX_W-1:0]      low_idx_o,
    output logic                  nonzero_o
);

    // Scanning from the top down lets the last hit win, which leaves the
    // lowest qualifying index in each result.
    always_comb begin
        next_idx_o   = '0;
        next_found_o = 1'b0;
        low_idx_o    = '0;
        for (int i = NUM_SENSOR - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                low_idx_o = IDX_W'(i);
                if (IDX_W'(i) > cur_idx_i) begin
                    next_idx_o   = IDX_W'(i);
                    next_found_o = 1'b1;
                end
            end
        end
    end

    assign nonzero_o = |mask_i;

endmodule
`default_nettype wire

// File: rtl/temp_sense_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : temp_sense_scan_ctrl
//  Purpose  : Sequences the shared 4-wire temperature-sense pads across the
//             on-die sensors one at a time: break-before-make gap, settle
//             time with switches closed, then a measurement window (timed or
//             STEP-terminated), then advance to the next masked-in sensor.
//  Ports    : ACLK / ARESET            - clock, synchronous active-high reset
//             SCAN_EN                  - run level; low aborts to IDLE
//             CONTINUOUS               - wrap to lowest sensor after a pass
//             STEP_MODE / STEP         - window ends on STEP pulse when set
//             SENSOR_MASK              - sensors included in the scan
//             SETTLE_CYCLES            - closed-switch time before window
//             DWELL_CYCLES             - window length in timed mode
//             SRC_SEL / SNS_SEL        - one-hot switch enables (identical)
//             MEAS_WINDOW              - meter may sample
//             CUR_IDX                  - sensor being / last driven
//             BUSY                     - controller not idle
//             SCAN_DONE                - one-cycle end-of-pass pulse
//  Notes    : All outputs come straight from flops. The end-of-pass decision
//             uses the mask seen during the NEXT cycle, so SCAN_DONE is high
//             in the cycle that follows NEXT (together with the first BREAK
//             cycle of a wrapped pass, or the first IDLE cycle).
//  Revision : 1.0  initial release
// ============================================================================
module temp_sense_scan_ctrl
    import temp_scan_pkg::*;
#(
    parameter int NUM_SENSOR = NUM_SENSOR_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int BBM_CYCLES = BBM_CYCLES_DEF,
    parameter int SETTLE_W   = SETTLE_W_DEF,
    parameter int DWELL_W    = DWELL_W_DEF
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  SCAN_EN,
    input  logic                  CONTINUOUS,
    input  logic                  STEP_MODE,
    input  logic                  STEP,
    input  logic [NUM_SENSOR-1:0] SENSOR_MASK,
    input  logic [SETTLE_W-1:0]   SETTLE_CYCLES,
    input  logic [DWELL_W-1:0]    DWELL_CYCLES,
    output logic [NUM_SENSOR-1:0] SRC_SEL,
    output logic [NUM_SENSOR-1:0] SNS_SEL,
    output logic                  MEAS_WINDOW,
    output logic [IDX_W-1:0]      CUR_IDX,
    output logic                  BUSY,
    output logic                  SCAN_DONE
);

    localparam int BBM_W = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
    localparam logic [BBM_W-1:0] BBM_LAST = BBM_W'(BBM_CYCLES - 1);

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BBM_W-1:0]      bbm_cnt_q, bbm_cnt_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [DWELL_W-1:0]    dwell_cnt_q, dwell_cnt_d;
    logic [SETTLE_W-1:0]   settle_lat_q, settle_lat_d;
    logic [DWELL_W-1:0]    dwell_lat_q, dwell_lat_d;
    logic                  step_lat_q, step_lat_d;
    logic [NUM_SENSOR-1:0] sel_q, sel_d;
    logic                  meas_q, meas_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [IDX_W-1:0]      next_idx;
    logic                  next_found;
    logic [IDX_W-1:0]      low_idx;
    logic                  mask_nonzero;
    logic                  dwell_last;

    mask_next_sel #(
        .NUM_SENSOR (NUM_SENSOR),
        .IDX_W      (IDX_W)
    ) u_mask_next_sel (
        .mask_i       (SENSOR_MASK),
        .cur_idx_i    (idx_q),
        .next_idx_o   (next_idx),
        .next_found_o (next_found),
        .low_idx_o    (low_idx),
        .nonzero_o    (mask_nonzero)
    );

    // A zero dwell length still gives a one-cycle window.
    assign dwell_last = (dwell_lat_q == '0) ||
                        (dwell_cnt_q == dwell_lat_q - DWELL_W'(1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bbm_cnt_d    = bbm_cnt_q;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        settle_lat_d = settle_lat_q;
        dwell_lat_d  = dwell_lat_q;
        step_lat_d   = step_lat_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (SCAN_EN && mask_nonzero) begin
                    idx_d     = low_idx;
                    bbm_cnt_d = '0;
                    state_d   = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (bbm_cnt_q == BBM_LAST) begin
                    // Timing config is frozen per sensor here so register
                    // writes mid-sensor only affect the following sensor.
                    settle_lat_d = SETTLE_CYCLES;
                    dwell_lat_d  = DWELL_CYCLES;
                    step_lat_d   = STEP_MODE;
                    settle_cnt_d = '0;
                    dwell_cnt_d  = '0;
                    state_d      = (SETTLE_CYCLES == '0) ? ST_DWELL : ST_SETTLE;
                end else begin
                    bbm_cnt_d = bbm_cnt_q + BBM_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == settle_lat_q - SETTLE_W'(1)) begin
                    dwell_cnt_d = '0;
                    state_d     = ST_DWELL;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            ST_DWELL: begin
                if (step_lat_q ? STEP : dwell_last) begin
                    state_d = ST_NEXT;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            ST_NEXT: begin
                if (next_found) begin
                    idx_d     = next_idx;
                    bbm_cnt_d = '0;
                    state_d   = ST_BREAK;
                end else begin
                    done_d = 1'b1;
                    if (CONTINUOUS && mask_nonzero) begin
                        idx_d     = low_idx;
                        bbm_cnt_d = '0;
                        state_d   = ST_BREAK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort: drop to IDLE, keep the last driven index, suppress SCAN_DONE.
        if (!SCAN_EN && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            done_d  = 1'b0;
        end
    end

    // Output flops are loaded from the next state, so switches open on entry
    // to BREAK/IDLE and close on entry to SETTLE (or DWELL when settle is 0).
    always_comb begin
        sel_d = '0;
        if ((state_d == ST_SETTLE) || (state_d == ST_DWELL) || (state_d == ST_NEXT)) begin
            sel_d = NUM_SENSOR'(onehot(IDX_MAX_W'(idx_d)));
        end
    end

    assign meas_d = (state_d == ST_DWELL);
    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            bbm_cnt_q    <= '0;
            settle_cnt_q <= '0;
            dwell_cnt_q  <= '0;
            settle_lat_q <= '0;
            dwell_lat_q  <= '0;
            step_lat_q   <= 1'b0;
            sel_q        <= '0;
            meas_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bbm_cnt_q    <= bbm_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            settle_lat_q <= settle_lat_d;
            dwell_lat_q  <= dwell_lat_d;
            step_lat_q   <= step_lat_d;
            sel_q        <= sel_d;
            meas_q       <= meas_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign SRC_SEL     = sel_q;
    assign SNS_SEL     = sel_q;
    assign MEAS_WINDOW = meas_q;
    assign CUR_IDX     = idx_q;
    assign BUSY        = busy_q;
    assign SCAN_DONE   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_sense_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_temp_sense_scan_ctrl
//  Purpose  : Self-checking bench for temp_sense_scan_ctrl (4-sensor build).
//             A timeline generator expands each scan scenario into the
//             expected per-cycle outputs (gap, settle, window, advance) and
//             the STEP/SCAN_EN drive, which is replayed against the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_temp_sense_scan_ctrl;

    localparam int NS    = 4;
    localparam int IW    = 2;
    localparam int BBM   = 2;
    localparam int SW    = 8;
    localparam int DW    = 16;
    localparam int ROW_W = NS + IW + 3;

    // Expected row layout: {done, busy, meas, idx, sel}
    typedef logic [ROW_W-1:0] row_t;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          SCAN_EN;
    logic          CONTINUOUS;
    logic          STEP_MODE;
    logic          STEP;
    logic [NS-1:0] SENSOR_MASK;
    logic [SW-1:0] SETTLE_CYCLES;
    logic [DW-1:0] DWELL_CYCLES;
    logic [NS-1:0] SRC_SEL;
    logic [NS-1:0] SNS_SEL;
    logic          MEAS_WINDOW;
    logic [IW-1:0] CUR_IDX;
    logic          BUSY;
    logic          SCAN_DONE;

    temp_sense_scan_ctrl #(
        .NUM_SENSOR (NS),
        .IDX_W      (IW),
        .BBM_CYCLES (BBM),
        .SETTLE_W   (SW),
        .DWELL_W    (DW)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .SCAN_EN       (SCAN_EN),
        .CONTINUOUS    (CONTINUOUS),
        .STEP_MODE     (STEP_MODE),
        .STEP          (STEP),
        .SENSOR_MASK   (SENSOR_MASK),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .DWELL_CYCLES  (DWELL_CYCLES),
        .SRC_SEL       (SRC_SEL),
        .SNS_SEL       (SNS_SEL),
        .MEAS_WINDOW   (MEAS_WINDOW),
        .CUR_IDX       (CUR_IDX),
        .BUSY          (BUSY),
        .SCAN_DONE     (SCAN_DONE)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    row_t tl[$];
    logic step_tl[$];
    logic en_tl[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic row_t mk(input int s, input bit sel_on, input bit meas,
                                input bit busy, input bit done);
        logic [NS-1:0] oh;
        logic [IW-1:0] ix;
        oh = '0;
        if (sel_on) oh[s] = 1'b1;
        ix = IW'(s);
        return {done, busy, meas, ix, oh};
    endfunction

    function automatic int row_idx(input row_t r);
        return int'(r[NS+IW-1:NS]);
    endfunction

    // Advance one clock, then compare all outputs (sampled 1ns after the edge).
    task automatic tick_check(input string tag, input row_t exp);
        row_t obs;
        @(posedge ACLK);
        #1;
        obs = {SCAN_DONE, BUSY, MEAS_WINDOW, CUR_IDX, SRC_SEL};
        check(tag, 32'(obs), 32'(exp));
        check({tag, ".sns"}, 32'(SNS_SEL), 32'(exp[NS-1:0]));
    endtask

    task automatic push(input row_t r, input logic st);
        tl.push_back(r);
        step_tl.push_back(st);
        en_tl.push_back(1'b1);
    endtask

    // Expand a scan into expected cycles starting with the cycle after the
    // SCAN_EN=1 sampling edge: per sensor BBM open cycles, settle cycles,
    // window cycles, one advance cycle; done flags the cycle after a pass.
    task automatic build(input logic [NS-1:0] mask, input int settle, input int dwell,
                         input bit stepm, input bit cont, input int npass, input int step_len);
        bit pend;
        int last;
        tl.delete();
        step_tl.delete();
        en_tl.delete();
        pend = 1'b0;
        last = 0;
        for (int p = 0; p < npass; p++) begin
            for (int s = 0; s < NS; s++) begin
                if (mask[s]) begin
                    int wl;
                    for (int b = 0; b < BBM; b++) begin
                        push(mk(s, 1'b0, 1'b0, 1'b1, pend), 1'($urandom_range(0, 1)));
                        pend = 1'b0;
                    end
                    for (int c = 0; c < settle; c++)
                        push(mk(s, 1'b1, 1'b0, 1'b1, 1'b0), 1'($urandom_range(0, 1)));
                    if (stepm) wl = (step_len > 0) ? step_len : int'($urandom_range(1, 12));
                    else       wl = (dwell == 0) ? 1 : dwell;
                    for (int w = 0; w < wl; w++) begin
                        logic st;
                        if (stepm) st = (w == wl - 1);
                        else       st = 1'($urandom_range(0, 1));
                        push(mk(s, 1'b1, 1'b1, 1'b1, 1'b0), st);
                    end
                    push(mk(s, 1'b1, 1'b0, 1'b1, 1'b0), 1'($urandom_range(0, 1)));
                    last = s;
                end
            end
            pend = 1'b1;
        end
        if (!cont) begin
            // Done cycle is idle; SCAN_EN is released there to avoid a restart.
            push(mk(last, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
            en_tl[en_tl.size()-1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                push(mk(last, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
                en_tl[en_tl.size()-1] = 1'b0;
            end
        end
    endtask

    // SCAN_EN low during row a: everything after it is idle with the index
    // held and no done pulse.
    task automatic apply_abort(input int a);
        int k;
        k = row_idx(tl[a]);
        for (int i = a; i < tl.size(); i++) en_tl[i] = 1'b0;
        for (int i = a + 1; i < tl.size(); i++) tl[i] = mk(k, 1'b0, 1'b0, 1'b0, 1'b0);
        while (tl.size() > a + 4) begin
            void'(tl.pop_back());
            void'(step_tl.pop_back());
            void'(en_tl.pop_back());
        end
    endtask

    task automatic set_cfg(input logic [NS-1:0] mask, input int settle, input int dwell,
                           input bit stepm, input bit cont);
        SENSOR_MASK   = mask;
        SETTLE_CYCLES = SW'(settle);
        DWELL_CYCLES  = DW'(dwell);
        STEP_MODE     = stepm;
        CONTINUOUS    = cont;
    endtask

    // Replay the timeline; reset_at >= 0 pulses ARESET during that row.
    task automatic run(input string name, input int reset_at);
        SCAN_EN = 1'b1;
        STEP    = 1'b0;
        for (int i = 0; i < tl.size(); i++) begin
            tick_check($sformatf("%s.c%0d", name, i + 1), tl[i]);
            if (i == reset_at) begin
                ARESET = 1'b1;
                tick_check($sformatf("%s.rst", name), mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
                ARESET  = 1'b0;
                SCAN_EN = 1'b0;
                STEP    = 1'b0;
                tick_check($sformatf("%s.post", name), mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
                break;
            end
            SCAN_EN = en_tl[i];
            STEP    = step_tl[i];
        end
        SCAN_EN = 1'b0;
        STEP    = 1'b0;
    endtask

    initial begin
        ARESET  = 1'b1;
        SCAN_EN = 1'b0;
        STEP    = 1'b0;
        set_cfg(4'b0000, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge ACLK);
        #1;
        check("reset", 32'({SCAN_DONE, BUSY, MEAS_WINDOW, CUR_IDX, SRC_SEL}), 32'(0));
        ARESET = 1'b0;

        // Empty mask: scan enable has no effect.
        SCAN_EN = 1'b1;
        for (int i = 0; i < 5; i++)
            tick_check($sformatf("mask0.c%0d", i), mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
        SCAN_EN = 1'b0;
        tick_check("mask0.end", mk(0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Single pass over 0,1,3: first window 1+2+3 cycles after enable.
        set_cfg(4'b1011, 3, 5, 1'b0, 1'b0);
        build(4'b1011, 3, 5, 1'b0, 1'b0, 1, 0);
        run("single", -1);

        // Continuous: three passes including 3->0 wraps, then abort.
        set_cfg(4'b1011, 3, 5, 1'b0, 1'b1);
        build(4'b1011, 3, 5, 1'b0, 1'b1, 3, 0);
        apply_abort(tl.size() - 5);
        run("cont", -1);

        // STEP-terminated 50-cycle window; stray STEPs elsewhere ignored.
        set_cfg(4'b0010, 3, 5, 1'b1, 1'b0);
        build(4'b0010, 3, 5, 1'b1, 1'b0, 1, 50);
        run("step50", -1);

        // Abort during settle of sensor 1 (rows 0..10 belong to sensor 0).
        set_cfg(4'b1011, 3, 5, 1'b0, 1'b0);
        build(4'b1011, 3, 5, 1'b0, 1'b0, 1, 0);
        apply_abort(13);
        run("abort_settle", -1);
        build(4'b1011, 3, 5, 1'b0, 1'b0, 1, 0);
        run("restart", -1);

        // Zero settle and zero dwell: one-cycle window 3 cycles after enable.
        set_cfg(4'b0100, 0, 0, 1'b0, 1'b0);
        build(4'b0100, 0, 0, 1'b0, 1'b0, 1, 0);
        run("zero_timing", -1);

        // Reset asserted in the middle of the first window.
        set_cfg(4'b1011, 3, 5, 1'b0, 1'b0);
        build(4'b1011, 3, 5, 1'b0, 1'b0, 1, 0);
        run("reset_dwell", 6);

        // Randomized scenarios.
        for (int n = 0; n < 25; n++) begin
            logic [NS-1:0] m;
            int st, dw;
            bit sm, ct;
            m  = NS'($urandom_range(1, 15));
            st = int'($urandom_range(0, 4));
            dw = int'($urandom_range(0, 6));
            sm = 1'($urandom_range(0, 1));
            ct = 1'($urandom_range(0, 1));
            set_cfg(m, st, dw, sm, ct);
            build(m, st, dw, sm, ct, ct ? int'($urandom_range(2, 3)) : 1, 0);
            if (ct || ($urandom_range(0, 9) < 3))
                apply_abort(int'($urandom_range(0, tl.size() - 2)));
            run($sformatf("rnd%0d", n), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
